// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared op encodings and helpers for the branch resolve unit
// Purpose: operation codes, branch classification helpers and the BHT counter
//          reset value, shared by branch_resolve_unit and bht_counters.
// Ports:   none (package).
package br_pkg;

    localparam logic [2:0] BR_NOP  = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BMI  = 3'b010;
    localparam logic [2:0] BR_BPL  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_CMOV = 3'b101;
    localparam logic [2:0] BR_BNZ  = 3'b110;
    localparam logic [2:0] BR_BLT  = 3'b111;

    // Anything that can redirect fetch: every op except NOP and CMOV.
    function automatic logic is_branch(input logic [2:0] op);
        return (op != BR_NOP) && (op != BR_CMOV);
    endfunction

    // Conditional branches train the BHT; BR is unconditional so it never does.
    function automatic logic is_cond(input logic [2:0] op);
        return is_branch(op) && (op != BR_BR);
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic int unsigned cnt_reset_value(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bht_counters.sv
// rtl/bht_counters.sv - array of saturating branch history counters
// Purpose: ENTRIES counters of CNT_BITS each, one combinational read port
//          (MSB of the indexed counter) and one synchronous update port.
// Ports:   clk, rst_n (async active-low)
//          rd_idx_i / rd_taken_o            - lookup index and predicted direction
//          upd_en_i / upd_idx_i / upd_taken_i - training request
module bht_counters
    import br_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CNT_BITS = 2,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_reset_value(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] upd_cur;
    logic [CNT_BITS-1:0] upd_d;

    // Read sees the registered value, so a same-cycle update to the same
    // index is not bypassed to the lookup.
    assign rd_taken_o = cnt_q[rd_idx_i][CNT_BITS-1];

    always_comb begin
        upd_cur = cnt_q[upd_idx_i];
        upd_d   = upd_cur;
        if (upd_taken_i) begin
            if (upd_cur != CNT_MAX) upd_d = upd_cur + CNT_BITS'(1);
        end else begin
            if (upd_cur != '0) upd_d = upd_cur - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= CNT_RST;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= upd_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - one-stage branch/CMOV resolver with BHT
// Purpose: resolves branches and CMOV in one registered stage behind a
//          valid/ready handshake, flags mispredictions and trains the BHT.
// Ports:   clk, rst_n (async active-low)
//          in_valid/in_ready, in_pc_plus_4, in_a, in_b, in_imm, in_op,
//          in_pred_taken            - request side
//          flush                    - kill in-flight / same-cycle request
//          out_valid/out_ready, out_npc, out_taken, out_mispredict,
//          out_cmov                 - result side
//          pred_pc / pred_taken     - combinational BHT lookup for fetch
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_op,
    input  logic            in_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_npc,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_cmov,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_npc_q, out_npc_d;
    logic            out_taken_q, out_taken_d;
    logic            out_misp_q, out_misp_d;
    logic [XLEN-1:0] out_cmov_q, out_cmov_d;

    logic            in_fire, accept, out_fire;
    logic            a_neg, a_zero, a_lt_b, taken_c;
    logic [XLEN-1:0] target_c;
    logic [IDX_W-1:0] upd_idx, rd_idx;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    // A flushed request still handshakes but leaves no trace.
    assign accept   = in_fire && !flush;

    assign a_neg    = in_a[XLEN-1];
    assign a_zero   = (in_a == '0);
    assign a_lt_b   = $signed(in_a) < $signed(in_b);
    assign target_c = in_pc_plus_4 + in_imm;

    always_comb begin
        taken_c = 1'b0;
        case (in_op)
            BR_BR:   taken_c = 1'b1;
            BR_BMI:  taken_c = a_neg;
            BR_BPL:  taken_c = !a_neg && !a_zero;
            BR_BZ:   taken_c = a_zero;
            BR_BNZ:  taken_c = !a_zero;
            BR_BLT:  taken_c = a_lt_b;
            default: taken_c = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_npc_d   = out_npc_q;
        out_taken_d = out_taken_q;
        out_misp_d  = out_misp_q;
        out_cmov_d  = out_cmov_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_npc_d   = taken_c ? target_c : in_pc_plus_4;
            out_taken_d = taken_c;
            out_misp_d  = is_branch(in_op) && (taken_c != in_pred_taken);
            out_cmov_d  = ((in_op == BR_CMOV) && !a_lt_b) ? in_b : in_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_npc_q   <= '0;
            out_taken_q <= 1'b0;
            out_misp_q  <= 1'b0;
            out_cmov_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_npc_q   <= out_npc_d;
            out_taken_q <= out_taken_d;
            out_misp_q  <= out_misp_d;
            out_cmov_q  <= out_cmov_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_npc        = out_npc_q;
    assign out_taken      = out_taken_q;
    assign out_mispredict = out_misp_q;
    assign out_cmov       = out_cmov_q;

    // The BHT is indexed by the instruction's own PC, i.e. pc_plus_4 - 4.
    assign upd_idx = IDX_W'((in_pc_plus_4 - XLEN'(4)) >> 2);
    assign rd_idx  = IDX_W'(pred_pc >> 2);

    bht_counters #(
        .ENTRIES  (BHT_ENTRIES),
        .CNT_BITS (CNT_BITS)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (rd_idx),
        .rd_taken_o  (pred_taken),
        .upd_en_i    (accept && is_cond(in_op)),
        .upd_idx_i   (upd_idx),
        .upd_taken_i (taken_c)
    );

endmodule
